ex_stage_pipe: RTL and testbench

Parametrised, registered execute stage for the pipelined CPU: ALU, next-PC computation (branch/jal/jalr) and write-data selection, with valid/ready handshakes on both sides. Adds a multi-cycle iterative multiplier, a pipeline flush input and registered sideband pass-through. Sits between the decode/ID-EX register and the memory stage, and replaces the purely combinational execute logic.

---
 rtl/ex_stage_pipe.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
// Registered execute stage: ALU, next-PC and write-data selection, with an
// iterative shift-add multiplier, flush support and valid/ready handshakes
// on both the upstream and downstream sides.
module ex_stage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 5,
    parameter logic [4:0]  MUL_OP = 5'h10,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    input  logic [4:0]        alu_op,
    input  logic [3:0]        jump_type,
    input  logic              reg_wrenable,
    input  logic              mem_wrenable,
    input  logic              mem_to_reg,
    input  logic [4:0]        write_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] write_data,
    output logic              out_reg_wrenable,
    output logic              out_mem_wrenable,
    output logic              out_mem_to_reg,
    output logic [4:0]        out_write_reg
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    // Single-cycle ALU opcodes
    localparam logic [4:0] ALU_ADD  = 5'h00;
    localparam logic [4:0] ALU_SUB  = 5'h01;
    localparam logic [4:0] ALU_SLL  = 5'h02;
    localparam logic [4:0] ALU_SLT  = 5'h03;
    localparam logic [4:0] ALU_SLTU = 5'h04;
    localparam logic [4:0] ALU_XOR  = 5'h05;
    localparam logic [4:0] ALU_SRL  = 5'h06;
    localparam logic [4:0] ALU_SRA  = 5'h07;
    localparam logic [4:0] ALU_OR   = 5'h08;
    localparam logic [4:0] ALU_AND  = 5'h09;
    localparam logic [4:0] ALU_OP2  = 5'h0A;
    localparam logic [4:0] ALU_SEQ  = 5'h0B;
    localparam logic [4:0] ALU_SNE  = 5'h0C;
    localparam logic [4:0] ALU_SGE  = 5'h0D;
    localparam logic [4:0] ALU_SGEU = 5'h0E;
    localparam logic [4:0] ALU_OP1  = 5'h0F;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // FSM and multiplier datapath
    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    // Values captured at multiply accept, released at multiply completion
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
    logic              pend_regwe_q, pend_regwe_d;
    logic              pend_memwe_q, pend_memwe_d;
    logic              pend_m2r_q, pend_m2r_d;
    logic [4:0]        pend_wreg_q, pend_wreg_d;

    // Output register
    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              regwe_q, regwe_d;
    logic              memwe_q, memwe_d;
    logic              m2r_q, m2r_d;
    logic [4:0]        wreg_q, wreg_d;

    // Combinational execute results for the instruction on the inputs
    logic [DATA_W-1:0] op2;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] alu_comb;
    logic [PC_W-1:0]   pc_comb;
    logic [DATA_W-1:0] wdata_comb;
    logic [DATA_W-1:0] link_val;

    logic accept;
    logic consume;
    logic is_mul;
    logic mul_last;
    logic [DATA_W-1:0] mul_sum;
    logic unused_jt;

    assign unused_jt = ^jump_type[3:2];

    assign is_mul   = (alu_op == MUL_OP);
    assign in_ready = (state_q == ST_IDLE) && (!valid_q || out_ready) && !flush && !rst;
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;
    assign mul_last = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);
    assign mul_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // ALU: operand select and single-cycle operations; unknown opcodes give 0
    always_comb begin
        op2      = alu_src ? imm : rd2;
        shamt    = op2[SH_W-1:0];
        alu_comb = '0;
        case (alu_op)
            ALU_ADD:  alu_comb = rd1 + op2;
            ALU_SUB:  alu_comb = rd1 - op2;
            ALU_SLL:  alu_comb = rd1 << shamt;
            ALU_SLT:  alu_comb = {{(DATA_W-1){1'b0}}, ($signed(rd1) < $signed(op2))};
            ALU_SLTU: alu_comb = {{(DATA_W-1){1'b0}}, (rd1 < op2)};
            ALU_XOR:  alu_comb = rd1 ^ op2;
            ALU_SRL:  alu_comb = rd1 >> shamt;
            ALU_SRA:  alu_comb = $unsigned($signed(rd1) >>> shamt);
            ALU_OR:   alu_comb = rd1 | op2;
            ALU_AND:  alu_comb = rd1 & op2;
            ALU_OP2:  alu_comb = op2;
            ALU_SEQ:  alu_comb = {{(DATA_W-1){1'b0}}, (rd1 == op2)};
            ALU_SNE:  alu_comb = {{(DATA_W-1){1'b0}}, (rd1 != op2)};
            ALU_SGE:  alu_comb = {{(DATA_W-1){1'b0}}, ($signed(rd1) >= $signed(op2))};
            ALU_SGEU: alu_comb = {{(DATA_W-1){1'b0}}, (rd1 >= op2)};
            ALU_OP1:  alu_comb = rd1;
            default:  alu_comb = '0;
        endcase
    end

    // Next PC (jalr target from the ALU, otherwise PC-relative, wrapping) and
    // write data (link address without PC wrap, otherwise store data)
    always_comb begin
        link_val   = {{(DATA_W-PC_W){1'b0}}, in_pc} + {{(DATA_W-1){1'b0}}, 1'b1};
        pc_comb    = (jump_type[1:0] == 2'b11) ? alu_comb[PC_W-1:0] : (in_pc + imm[PC_W-1:0]);
        wdata_comb = jump_type[1] ? link_val : rd2;
    end

    // Next-state logic: accept, multiply iteration, completion and flush
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        pend_pc_d    = pend_pc_q;
        pend_wdata_d = pend_wdata_q;
        pend_regwe_d = pend_regwe_q;
        pend_memwe_d = pend_memwe_q;
        pend_m2r_d   = pend_m2r_q;
        pend_wreg_d  = pend_wreg_q;
        valid_d      = valid_q;
        pc_d         = pc_q;
        res_d        = res_q;
        wdata_d      = wdata_q;
        regwe_d      = regwe_q;
        memwe_d      = memwe_q;
        m2r_d        = m2r_q;
        wreg_d       = wreg_q;

        if (consume) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (is_mul) begin
                state_d      = ST_BUSY;
                cnt_d        = '0;
                mcand_d      = rd1;
                mplier_d     = op2;
                acc_d        = '0;
                pend_pc_d    = pc_comb;
                pend_wdata_d = wdata_comb;
                pend_regwe_d = reg_wrenable;
                pend_memwe_d = mem_wrenable;
                pend_m2r_d   = mem_to_reg;
                pend_wreg_d  = write_reg;
            end else begin
                valid_d = 1'b1;
                pc_d    = pc_comb;
                res_d   = alu_comb;
                wdata_d = wdata_comb;
                regwe_d = reg_wrenable;
                memwe_d = mem_wrenable;
                m2r_d   = mem_to_reg;
                wreg_d  = write_reg;
            end
        end

        if (state_q == ST_BUSY) begin
            acc_d    = mul_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (mul_last) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                valid_d = 1'b1;
                res_d   = mul_sum;
                pc_d    = pend_pc_q;
                wdata_d = pend_wdata_q;
                regwe_d = pend_regwe_q;
                memwe_d = pend_memwe_q;
                m2r_d   = pend_m2r_q;
                wreg_d  = pend_wreg_q;
            end
        end

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            pend_pc_q    <= '0;
            pend_wdata_q <= '0;
            pend_regwe_q <= 1'b0;
            pend_memwe_q <= 1'b0;
            pend_m2r_q   <= 1'b0;
            pend_wreg_q  <= '0;
            valid_q      <= 1'b0;
            pc_q         <= '0;
            res_q        <= '0;
            wdata_q      <= '0;
            regwe_q      <= 1'b0;
            memwe_q      <= 1'b0;
            m2r_q        <= 1'b0;
            wreg_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            pend_pc_q    <= pend_pc_d;
            pend_wdata_q <= pend_wdata_d;
            pend_regwe_q <= pend_regwe_d;
            pend_memwe_q <= pend_memwe_d;
            pend_m2r_q   <= pend_m2r_d;
            pend_wreg_q  <= pend_wreg_d;
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            res_q        <= res_d;
            wdata_q      <= wdata_d;
            regwe_q      <= regwe_d;
            memwe_q      <= memwe_d;
            m2r_q        <= m2r_d;
            wreg_q       <= wreg_d;
        end
    end

    assign out_valid        = valid_q;
    assign out_pc           = pc_q;
    assign alu_res          = res_q;
    assign write_data       = wdata_q;
    assign out_reg_wrenable = regwe_q;
    assign out_mem_wrenable = memwe_q;
    assign out_mem_to_reg   = m2r_q;
    assign out_write_reg    = wreg_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed testbench for ex_stage_pipe: reset, ALU ops, jumps, multiply
// latency, back-pressure, flush and reset during a multiply.
module tb_ex_stage_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_pc;
    logic [31:0] rd1, rd2, imm;
    logic        alu_src;
    logic [4:0]  alu_op;
    logic [3:0]  jump_type;
    logic        reg_wrenable, mem_wrenable, mem_to_reg;
    logic [4:0]  write_reg;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_pc;
    logic [31:0] alu_res, write_data;
    logic        out_reg_wrenable, out_mem_wrenable, out_mem_to_reg;
    logic [4:0]  out_write_reg;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_MUL = 5'h10;

    ex_stage_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .rd1(rd1), .rd2(rd2), .imm(imm), .alu_src(alu_src), .alu_op(alu_op),
        .jump_type(jump_type), .reg_wrenable(reg_wrenable),
        .mem_wrenable(mem_wrenable), .mem_to_reg(mem_to_reg),
        .write_reg(write_reg), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .alu_res(alu_res), .write_data(write_data),
        .out_reg_wrenable(out_reg_wrenable), .out_mem_wrenable(out_mem_wrenable),
        .out_mem_to_reg(out_mem_to_reg), .out_write_reg(out_write_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to the stage (sideband fixed: regwe=1, memwe=0, m2r=1)
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic src, input logic [4:0] pc,
                                 input logic [3:0] jt, input logic [4:0] wr);
        in_valid     = 1'b1;
        alu_op       = op;
        rd1          = a;
        rd2          = b;
        imm          = im;
        alu_src      = src;
        in_pc        = pc;
        jump_type    = jt;
        write_reg    = wr;
        reg_wrenable = 1'b1;
        mem_wrenable = 1'b0;
        mem_to_reg   = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        applyStimulus(OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 5'd4, 4'b0000, 5'd9);
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0h expected 0", in_ready); end
        checks++; if (alu_res !== 32'd0 || write_data !== 32'd0 || out_pc !== 5'd0) begin errors++; $display("[TB] FAIL reset_data: got res=%0h wd=%0h pc=%0h expected 0", alu_res, write_data, out_pc); end
        checks++; if ({out_reg_wrenable, out_mem_wrenable, out_mem_to_reg, out_write_reg} !== 8'd0) begin errors++; $display("[TB] FAIL reset_sideband: got %0h expected 0", {out_reg_wrenable, out_mem_wrenable, out_mem_to_reg, out_write_reg}); end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %0h expected 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_valid: got %0h expected 0", out_valid); end
    endtask

    task automatic test_add();
        applyStimulus(OP_ADD, 32'd5, 32'hAB, 32'd7, 1'b1, 5'd3, 4'b0000, 5'd3);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_in_ready: got %0h expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %0h expected 1", out_valid); end
        checks++; if (alu_res !== 32'd12) begin errors++; $display("[TB] FAIL add_res: got %0h expected c", alu_res); end
        checks++; if (out_pc !== 5'd10) begin errors++; $display("[TB] FAIL add_pc: got %0d expected 10", out_pc); end
        checks++; if (write_data !== 32'hAB) begin errors++; $display("[TB] FAIL add_wdata: got %0h expected ab", write_data); end
        checks++; if ({out_reg_wrenable, out_mem_wrenable, out_mem_to_reg, out_write_reg} !== {3'b101, 5'd3}) begin errors++; $display("[TB] FAIL add_sideband: got %0h expected a3", {out_reg_wrenable, out_mem_wrenable, out_mem_to_reg, out_write_reg}); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_drain: got %0h expected 0", out_valid); end
    endtask

    task automatic test_alu_ops();
        logic [4:0]  ops [11] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h11, 5'h1F};
        logic [31:0] av  [11] = '{32'd5, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0, 32'h80000000, 32'h80000000, 32'hF0, 32'hF0, 32'd9, 32'd9};
        logic [31:0] bv  [11] = '{32'd7, 32'd4, 32'd1, 32'd1, 32'hFF, 32'd4, 32'd4, 32'h0F, 32'h3C, 32'd3, 32'd3};
        logic [31:0] ev  [11] = '{32'hFFFFFFFE, 32'h10, 32'd1, 32'd0, 32'h0F, 32'h08000000, 32'hF8000000, 32'hFF, 32'h30, 32'd0, 32'd0};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(ops[i], av[i], bv[i], 32'd0, 1'b0, 5'd0, 4'b0000, 5'd1);
            step();
            checks++; if (out_valid !== 1'b1 || alu_res !== ev[i]) begin errors++; $display("[TB] FAIL alu_op_%0h: got valid=%0h res=%0h expected valid=1 res=%0h", ops[i], out_valid, alu_res, ev[i]); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_jump();
        applyStimulus(OP_ADD, 32'd0, 32'd0, 32'd2, 1'b1, 5'd31, 4'b0010, 5'd1);
        step();
        checks++; if (out_pc !== 5'd1) begin errors++; $display("[TB] FAIL jal_pc: got %0d expected 1", out_pc); end
        checks++; if (write_data !== 32'd32) begin errors++; $display("[TB] FAIL jal_link: got %0d expected 32", write_data); end
        applyStimulus(OP_ADD, 32'd20, 32'd0, 32'd4, 1'b1, 5'd0, 4'b0011, 5'd2);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL jalr_in_ready: got %0h expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 5'd24 || alu_res !== 32'd24) begin errors++; $display("[TB] FAIL jalr_pc: got valid=%0h pc=%0d res=%0d expected 1/24/24", out_valid, out_pc, alu_res); end
        checks++; if (write_data !== 32'd1 || out_write_reg !== 5'd2) begin errors++; $display("[TB] FAIL jalr_link: got wd=%0d wr=%0d expected 1/2", write_data, out_write_reg); end
        step();
    endtask

    task automatic test_mul();
        int waited;
        applyStimulus(OP_MUL, 32'hFFFFFFFF, 32'd3, 32'd1, 1'b0, 5'd4, 4'b0000, 5'd7);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mul_in_ready: got %0h expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mul_busy_%0d: got ready=%0h valid=%0h expected 0/0", k, in_ready, out_valid); end
            step();
        end
        checks++; if (out_valid !== 1'b1 || alu_res !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL mul_res: got valid=%0h res=%0h expected 1/fffffffd", out_valid, alu_res); end
        checks++; if (out_write_reg !== 5'd7 || out_pc !== 5'd5 || write_data !== 32'd3 || out_mem_to_reg !== 1'b1) begin errors++; $display("[TB] FAIL mul_sideband: got wr=%0d pc=%0d wd=%0h m2r=%0h expected 7/5/3/1", out_write_reg, out_pc, write_data, out_mem_to_reg); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mul_done_ready: got %0h expected 1", in_ready); end
        step();
        applyStimulus(OP_MUL, 32'd6, 32'd0, 32'd9, 1'b1, 5'd0, 4'b0000, 5'd8);
        step();
        in_valid = 1'b0;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        checks++; if (waited !== 32 || alu_res !== 32'd54) begin errors++; $display("[TB] FAIL mul_latency: got wait=%0d res=%0d expected 32/54", waited, alu_res); end
        step();
    endtask

    task automatic test_back_to_back();
        applyStimulus(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd0, 4'b0000, 5'd1);
        step();
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 5'd0, 4'b0000, 5'd2);
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || alu_res !== 32'd3 || out_write_reg !== 5'd1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_%0d: got valid=%0h res=%0d wr=%0d ready=%0h expected 1/3/1/0", k, out_valid, alu_res, out_write_reg, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || alu_res !== 32'd3) begin errors++; $display("[TB] FAIL release_ready: got ready=%0h res=%0d expected 1/3", in_ready, alu_res); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || alu_res !== 32'd30) begin errors++; $display("[TB] FAIL second_res: got valid=%0h res=%0d expected 1/30", out_valid, alu_res); end
        step();
    endtask

    task automatic test_flush();
        int seen;
        applyStimulus(OP_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 5'd0, 4'b0000, 5'd5);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready: got %0h expected 0", in_ready); end
        step();
        flush = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL after_flush: got valid=%0h ready=%0h expected 0/1", out_valid, in_ready); end
        applyStimulus(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd0, 4'b0000, 5'd6);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || alu_res !== 32'd2) begin errors++; $display("[TB] FAIL flush_add: got valid=%0h res=%0d expected 1/2", out_valid, alu_res); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL flushed_mul_rose: got %0d valid cycles expected 0", seen); end
        applyStimulus(OP_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 5'd0, 4'b0000, 5'd6);
        step();
        out_ready = 1'b0;
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || alu_res !== 32'd5) begin errors++; $display("[TB] FAIL held_before_flush: got valid=%0h res=%0d expected 1/5", out_valid, alu_res); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_held: got %0h expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        applyStimulus(OP_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 5'd3, 4'b0000, 5'd4);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || alu_res !== 32'd0 || out_pc !== 5'd0 || out_write_reg !== 5'd0) begin errors++; $display("[TB] FAIL rst_mul_clear: got valid=%0h res=%0h pc=%0h wr=%0h expected 0", out_valid, alu_res, out_pc, out_write_reg); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mul_ready: got %0h expected 1", in_ready); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL rst_mul_rose: got %0d valid cycles expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_jump();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
